gestor_conmutacion_baterias: RTL and testbench



---
 rtl/gestor_baterias_pkg.sv | 19 +
 rtl/gestor_conmutacion_baterias_filtro.sv | 44 ++++
 rtl/gestor_conmutacion_baterias.sv | 159 +++++++++++++++
 tb/tb_gestor_conmutacion_baterias.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gestor_baterias_pkg.sv
// Shared types and constants for the battery switchover manager.
package gestor_baterias_pkg;

    typedef enum logic [1:0] {
        USAR_B1     = 2'd0,
        USAR_B2     = 2'd1,
        CONMUTANDO  = 2'd2,
        SIN_ENERGIA = 2'd3
    } estado_t;

    localparam logic BAT1   = 1'b0;
    localparam logic BAT2   = 1'b1;
    localparam int   CONT_W = 8;

    function automatic logic [CONT_W-1:0] incr_sat(input logic [CONT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gestor_conmutacion_baterias_filtro.sv
// Debounce filter for one raw warning; also exposes the flag's next value so
// downstream logic can react on the same edge the change is confirmed.
module filtro_advertencia
    import gestor_baterias_pkg::*;
#(
    parameter int FILTRO_CICLOS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advertencia_i,
    output logic confirmado_o,
    output logic confirmado_sig_o
);

    localparam int CW = (FILTRO_CICLOS > 1) ? $clog2(FILTRO_CICLOS) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          conf_q, conf_d;

    always_comb begin
        cnt_d  = '0;
        conf_d = conf_q;
        if (advertencia_i != conf_q) begin
            if (cnt_q == CW'(FILTRO_CICLOS - 1))
                conf_d = ~conf_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            conf_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            conf_q <= conf_d;
        end
    end

    assign confirmado_o     = conf_q;
    assign confirmado_sig_o = conf_d;

endmodule

// File: rtl/gestor_conmutacion_baterias.sv
// Filters the discharge warnings and runs a break-before-make power-path FSM
// with operator alarms, alert LED, shutdown flag and switchover counter.
module gestor_conmutacion_baterias
    import gestor_baterias_pkg::*;
#(
    parameter int FILTRO_CICLOS    = 4,
    parameter int TIEMPO_MUERTO    = 3,
    parameter int PERIODO_PARPADEO = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advertencia_bateria_1,
    input  logic              advertencia_bateria_2,
    input  logic              reconocer,
    output logic              habilitar_b1,
    output logic              habilitar_b2,
    output logic              bateria_activa,
    output logic              alarma_bat1,
    output logic              alarma_bat2,
    output logic              led_alerta,
    output logic              apagado_sistema,
    output logic [CONT_W-1:0] contador_conmutaciones
);

    localparam int MW = (TIEMPO_MUERTO > 1) ? $clog2(TIEMPO_MUERTO) : 1;
    localparam int PW = (PERIODO_PARPADEO > 1) ? $clog2(PERIODO_PARPADEO) : 1;

    logic [1:0] desc_q, desc_d;

    filtro_advertencia #(.FILTRO_CICLOS(FILTRO_CICLOS)) u_filtro_b1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .advertencia_i    (advertencia_bateria_1),
        .confirmado_o     (desc_q[BAT1]),
        .confirmado_sig_o (desc_d[BAT1])
    );

    filtro_advertencia #(.FILTRO_CICLOS(FILTRO_CICLOS)) u_filtro_b2 (
        .clk              (clk),
        .rst_n            (rst_n),
        .advertencia_i    (advertencia_bateria_2),
        .confirmado_o     (desc_q[BAT2]),
        .confirmado_sig_o (desc_d[BAT2])
    );

    estado_t           estado_q, estado_d;
    logic              objetivo_q, objetivo_d;
    logic [MW-1:0]     muerto_q, muerto_d;
    logic              conmut_ok;
    logic              hab1_q, hab2_q, activa_q;
    logic [1:0]        alarma_q, alarma_d;
    logic              parpadeo_q, parpadeo_d;
    logic [PW-1:0]     fase_q, fase_d;
    logic [CONT_W-1:0] cuenta_q;

    // Decisions use the filters' next values so enables react on the confirming edge.
    always_comb begin
        estado_d   = estado_q;
        objetivo_d = objetivo_q;
        muerto_d   = muerto_q;
        conmut_ok  = 1'b0;
        case (estado_q)
            USAR_B1: begin
                if (desc_d[BAT1] && desc_d[BAT2]) begin
                    estado_d = SIN_ENERGIA;
                end else if (desc_d[BAT1]) begin
                    estado_d   = CONMUTANDO;
                    objetivo_d = BAT2;
                    muerto_d   = '0;
                end
            end
            USAR_B2: begin
                if (desc_d[BAT1] && desc_d[BAT2]) begin
                    estado_d = SIN_ENERGIA;
                end else if (desc_d[BAT2]) begin
                    estado_d   = CONMUTANDO;
                    objetivo_d = BAT1;
                    muerto_d   = '0;
                end
            end
            CONMUTANDO: begin
                if (desc_d[objetivo_q]) begin
                    estado_d = SIN_ENERGIA;
                end else if (muerto_q == MW'(TIEMPO_MUERTO - 1)) begin
                    estado_d  = (objetivo_q == BAT2) ? USAR_B2 : USAR_B1;
                    conmut_ok = 1'b1;
                end else begin
                    muerto_d = muerto_q + 1'b1;
                end
            end
            SIN_ENERGIA: begin
                if (!desc_d[BAT1]) begin
                    estado_d   = CONMUTANDO;
                    objetivo_d = BAT1;
                    muerto_d   = '0;
                end else if (!desc_d[BAT2]) begin
                    estado_d   = CONMUTANDO;
                    objetivo_d = BAT2;
                    muerto_d   = '0;
                end
            end
            default: estado_d = USAR_B1;
        endcase
    end

    // Set on the confirming edge beats a simultaneous acknowledge.
    always_comb begin
        alarma_d = (desc_d & ~desc_q) | (alarma_q & ~({2{reconocer}} & ~desc_q));
    end

    always_comb begin
        parpadeo_d = 1'b0;
        fase_d     = '0;
        if (|alarma_q) begin
            parpadeo_d = (fase_q == '0) ? ~parpadeo_q : parpadeo_q;
            fase_d     = (fase_q == PW'(PERIODO_PARPADEO - 1)) ? '0 : fase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q   <= USAR_B1;
            objetivo_q <= BAT1;
            muerto_q   <= '0;
            hab1_q     <= 1'b1;
            hab2_q     <= 1'b0;
            activa_q   <= BAT1;
            alarma_q   <= '0;
            parpadeo_q <= 1'b0;
            fase_q     <= '0;
            cuenta_q   <= '0;
        end else begin
            estado_q   <= estado_d;
            objetivo_q <= objetivo_d;
            muerto_q   <= muerto_d;
            hab1_q     <= (estado_d == USAR_B1);
            hab2_q     <= (estado_d == USAR_B2);
            if (estado_d == USAR_B1)
                activa_q <= BAT1;
            else if (estado_d == USAR_B2)
                activa_q <= BAT2;
            alarma_q   <= alarma_d;
            parpadeo_q <= parpadeo_d;
            fase_q     <= fase_d;
            if (conmut_ok)
                cuenta_q <= incr_sat(cuenta_q);
        end
    end

    assign habilitar_b1           = hab1_q;
    assign habilitar_b2           = hab2_q;
    assign bateria_activa         = activa_q;
    assign alarma_bat1            = alarma_q[BAT1];
    assign alarma_bat2            = alarma_q[BAT2];
    assign apagado_sistema        = (estado_q == SIN_ENERGIA);
    assign led_alerta             = (estado_q == SIN_ENERGIA) | parpadeo_q;
    assign contador_conmutaciones = cuenta_q;

endmodule

// File: tb/tb_gestor_conmutacion_baterias.sv
// Scoreboard bench: a behavioural model predicts each post-edge output set,
// a separate monitor compares the DUT against the queued predictions.
module tb_gestor_conmutacion_baterias;

    localparam int F = 4;
    localparam int T = 3;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       adv1 = 1'b0;
    logic       adv2 = 1'b0;
    logic       rec = 1'b0;
    logic       hab1, hab2, activa, al1, al2, led, apag_o;
    logic [7:0] cnt;

    always #5 clk = ~clk;

    gestor_conmutacion_baterias #(
        .FILTRO_CICLOS    (F),
        .TIEMPO_MUERTO    (T),
        .PERIODO_PARPADEO (P)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .advertencia_bateria_1  (adv1),
        .advertencia_bateria_2  (adv2),
        .reconocer              (rec),
        .habilitar_b1           (hab1),
        .habilitar_b2           (hab2),
        .bateria_activa         (activa),
        .alarma_bat1            (al1),
        .alarma_bat2            (al2),
        .led_alerta             (led),
        .apagado_sistema        (apag_o),
        .contador_conmutaciones (cnt)
    );

    typedef struct packed {
        logic       en1;
        logic       en2;
        logic       act;
        logic       al1;
        logic       al2;
        logic       led;
        logic       apag;
        logic [7:0] cnt;
    } salida_t;

    salida_t esperado_q[$];
    int      checks = 0;
    int      errors = 0;

    // Model state: which battery is wired to the load (-1 = none), pending
    // dead cycles, shutdown flag, and edges elapsed with an alarm latched.
    int run [2];
    bit conf[2];
    bit alarma[2];
    int conectada;
    int destino;
    int restantes;
    bit apagado;
    bit activa_m;
    int latido;
    int cuenta;

    task automatic iniciar(input int d);
        apagado   = 1'b0;
        conectada = -1;
        destino   = d;
        restantes = T;
    endtask

    task automatic modelo_paso(input bit a1, input bit a2, input bit rc, input bit rn,
                               output salida_t s);
        bit raw[2];
        bit nuevo[2];
        bit alguna_alarma;
        raw[0] = a1;
        raw[1] = a2;
        if (!rn) begin
            run = '{0, 0}; conf = '{0, 0}; alarma = '{0, 0};
            conectada = 0; destino = 0; restantes = 0;
            apagado = 1'b0; activa_m = 1'b0; latido = 0; cuenta = 0;
        end else begin
            alguna_alarma = alarma[0] | alarma[1];
            for (int b = 0; b < 2; b++) begin
                nuevo[b] = conf[b];
                if (raw[b] != conf[b]) begin
                    run[b]++;
                    if (run[b] == F) begin
                        nuevo[b] = !conf[b];
                        run[b] = 0;
                    end
                end else begin
                    run[b] = 0;
                end
            end
            if (apagado) begin
                if (!nuevo[0]) iniciar(0);
                else if (!nuevo[1]) iniciar(1);
            end else if (restantes > 0) begin
                if (nuevo[destino]) begin
                    apagado = 1'b1;
                    restantes = 0;
                end else begin
                    restantes--;
                    if (restantes == 0) begin
                        conectada = destino;
                        activa_m  = (destino == 1);
                        if (cuenta < 255) cuenta++;
                    end
                end
            end else if (nuevo[0] && nuevo[1]) begin
                apagado = 1'b1;
                conectada = -1;
            end else if (nuevo[conectada]) begin
                iniciar(1 - conectada);
            end
            for (int b = 0; b < 2; b++) begin
                if (nuevo[b] && !conf[b]) alarma[b] = 1'b1;
                else if (rc && !conf[b]) alarma[b] = 1'b0;
            end
            latido = alguna_alarma ? latido + 1 : 0;
            conf = nuevo;
        end
        s.en1  = (conectada == 0);
        s.en2  = (conectada == 1);
        s.act  = activa_m;
        s.al1  = alarma[0];
        s.al2  = alarma[1];
        s.apag = apagado;
        s.led  = apagado ? 1'b1 : (latido > 0 && (((latido - 1) / P) % 2) == 0);
        s.cnt  = cuenta[7:0];
    endtask

    task automatic ciclo(input bit a1, input bit a2, input bit rc, input bit rn);
        salida_t s;
        adv1  = a1;
        adv2  = a2;
        rec   = rc;
        rst_n = rn;
        modelo_paso(a1, a2, rc, rn, s);
        esperado_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nombre, input logic [7:0] actual, input logic [7:0] req);
        checks++;
        if (actual !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at t=%0t", nombre, actual, req, $time);
        end
    endtask

    initial begin : monitor
        salida_t e;
        forever begin
            @(posedge clk);
            #2;
            if (esperado_q.size() > 0) begin
                e = esperado_q.pop_front();
                chk("habilitar_b1",   {7'd0, hab1},   {7'd0, e.en1});
                chk("habilitar_b2",   {7'd0, hab2},   {7'd0, e.en2});
                chk("bateria_activa", {7'd0, activa}, {7'd0, e.act});
                chk("alarma_bat1",    {7'd0, al1},    {7'd0, e.al1});
                chk("alarma_bat2",    {7'd0, al2},    {7'd0, e.al2});
                chk("led_alerta",     {7'd0, led},    {7'd0, e.led});
                chk("apagado",        {7'd0, apag_o}, {7'd0, e.apag});
                chk("contador",       cnt,            e.cnt);
            end
        end
    end

    initial begin : estimulo
        bit r1, r2;
        repeat (2) ciclo(0, 0, 0, 0);
        repeat (3) ciclo(0, 0, 0, 1);
        // Short glitch, then sustained warning 1 and switchover to battery 2.
        repeat (3) ciclo(1, 0, 0, 1);
        repeat (4) ciclo(0, 0, 0, 1);
        repeat (20) ciclo(1, 0, 0, 1);
        ciclo(1, 0, 1, 1);
        repeat (3) ciclo(1, 0, 0, 1);
        repeat (5) ciclo(0, 0, 0, 1);
        ciclo(0, 0, 1, 1);
        repeat (4) ciclo(0, 0, 0, 1);
        // Both discharged, then battery 1 recovers.
        repeat (6) ciclo(1, 0, 0, 1);
        repeat (6) ciclo(1, 1, 0, 1);
        repeat (12) ciclo(0, 1, 0, 1);
        repeat (6) ciclo(0, 0, 0, 1);
        // Reset during the dead time.
        repeat (5) ciclo(1, 0, 0, 1);
        ciclo(1, 0, 0, 0);
        repeat (3) ciclo(0, 0, 0, 1);
        // Ping-pong to push the counter past saturation.
        repeat (160) begin
            repeat (10) ciclo(1, 0, 0, 1);
            repeat (10) ciclo(0, 1, 0, 1);
        end
        repeat (12) ciclo(0, 0, 1, 1);
        // Random traffic.
        r1 = 1'b0;
        r2 = 1'b0;
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) r1 = !r1;
            if ($urandom_range(0, 7) == 0) r2 = !r2;
            ciclo(r1, r2, ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) != 0));
        end
        repeat (3) ciclo(0, 0, 0, 1);
        #10;
        chk("cola_pendiente", 8'(esperado_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
